sys_cmd_decoder: RTL and testbench
==================================

// Module: sys_cmd_decoder
// PURPOSE
//  Command-frame decoder between the RX data synchronizer and the register file / ALU, in the REF_CLK domain.
//  Consumes synchronized RX bytes and executes register writes/reads and ALU operations.
//  Each read/ALU result goes out as a response word to the TX packer that feeds the async FIFO.
//  Frames: AA addr data | BB addr | CC opA opB fun | DD fun.
// PARAMETERS
//  DATA_WIDTH     8    byte width of RX data, register data, ALU operands
//  ADDR_WIDTH     4    register-file address width
//  NUM_REGS       8    implemented registers; addr >= NUM_REGS is illegal
//  FUN_WIDTH      4    ALU function select width
//  TIMEOUT_CYCLES 255  max wait for RdData_Valid / OUT_Valid; counter width = $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk          in   1             REF_CLK domain clock
//  rst          in   1             synchronous, active-low reset
//  RX_P_DATA    in   DATA_WIDTH    synchronized RX byte
//  RX_D_VLD     in   1             1-cycle pulse per RX byte
//  WrEn         out  1             register-file write strobe, 1 cycle
//  RdEn         out  1             register-file read strobe, 1 cycle
//  address      out  ADDR_WIDTH    register-file address
//  WrData       out  DATA_WIDTH    register-file write data
//  RdData       in   DATA_WIDTH    register-file read data
//  RdData_Valid in   1             read data valid, 1 cycle
//  ALU_FUN      out  FUN_WIDTH     ALU function select
//  ALU_EN       out  1             ALU enable
//  CLK_EN       out  1             ALU clock-gate enable
//  ALU_OUT      in   2*DATA_WIDTH  ALU result
//  OUT_Valid    in   1             ALU result valid, 1 cycle
//  RSP_DATA     out  2*DATA_WIDTH  response word
//  RSP_LEN      out  1             0: 1 byte (RSP_DATA[7:0]); 1: 2 bytes
//  RSP_VLD      out  1             response valid, held until accepted
//  RSP_RDY      in   1             TX packer ready
//  clk_div_en   out  1             UART clock-divider enable; 0 in reset, 1 afterwards
//  cmd_error    out  1             1-cycle pulse: bad opcode, bad address, timeout
//  overrun      out  1             1-cycle pulse: RX byte arrived in a non-accepting state
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state IDLE, all outputs 0, timeout counter 0, held fields 0.
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FN, ALU_WAIT, RSP.
//  IDLE on byte: AA->WR_ADDR, BB->RD_ADDR, CC->ALU_A, DD->ALU_FN; any other value -> cmd_error, stay IDLE.
//  WR_ADDR/RD_ADDR: addr >= NUM_REGS -> cmd_error, IDLE. Else latch address[ADDR_WIDTH-1:0]; go WR_DATA / RD_WAIT.
//   RD_ADDR also pulses RdEn on the next cycle.
//  WR_DATA on byte: WrEn=1 for 1 cycle with latched address and WrData=byte; ->IDLE. No response.
//  ALU_A on byte: WrEn pulse, address=0, WrData=opA; ->ALU_B.
//  ALU_B on byte: WrEn pulse, address=1, WrData=opB; ->ALU_FN.
//  ALU_FN on byte: latch ALU_FUN=byte[FUN_WIDTH-1:0]; ->ALU_WAIT.
//   ALU_EN and CLK_EN assert the cycle after the fun byte; both held until OUT_Valid is sampled, deasserted the next cycle.
//  RD_WAIT on RdData_Valid: RSP_DATA={0,RdData}, RSP_LEN=0, RSP_VLD=1; ->RSP.
//  ALU_WAIT on OUT_Valid: RSP_DATA=ALU_OUT, RSP_LEN=1, RSP_VLD=1; ->RSP.
//  Timeout: counter clears on WAIT entry and counts each WAIT cycle. Reaching TIMEOUT_CYCLES -> cmd_error pulse, ALU_EN/CLK_EN drop, ->IDLE.
//   A valid strobe in the same cycle as the final count wins; no error.
//  RSP: RSP_DATA/RSP_LEN stable while RSP_VLD=1. Transfer when RSP_VLD&RSP_RDY; RSP_VLD clears next cycle; ->IDLE.
//   RSP_RDY high on entry gives a 1-cycle response.
//  RX_D_VLD in RD_WAIT, ALU_WAIT or RSP: byte dropped, overrun pulse, state unchanged.
//  Frame bytes may arrive any number of cycles apart; no inter-byte timeout.
//  Strobes (WrEn/RdEn/ALU_EN/CLK_EN) never overlap. WrEn and RdEn are never high together.
//  clk_div_en: registered 1 from the first cycle after reset release.
//  rst low mid-frame or mid-wait: immediate return to IDLE with reset values; pending response discarded.
// STRUCTURE
//  Shared package: opcode constants (AA/BB/CC/DD), state enum, ALU operand register addresses (0, 1).
//  Single module with one FSM. Timeout counter inline; no sub-module needed.
// TESTING
//  1. AA 05 3C -> WrEn one pulse, address=5, WrData=3C; no RSP_VLD; state IDLE.
//  2. BB 05, RdData=3C valid 2 cycles after RdEn -> RSP_VLD, RSP_DATA=003C, RSP_LEN=0; RSP_RDY low 3 cycles, data held.
//  3. CC 0A 14 00, ALU returns 001E with OUT_Valid -> WrEn at addr 0 (0A) then addr 1 (14); ALU_FUN=0; CLK_EN/ALU_EN high until OUT_Valid; RSP_DATA=001E, RSP_LEN=1.
//  4. Illegal inputs: byte 7F in IDLE -> cmd_error pulse. BB 09 (NUM_REGS=8) -> cmd_error, no RdEn.
//     RdData_Valid never arrives -> cmd_error after 255 wait cycles, IDLE.
//  5. RX byte during ALU_WAIT -> overrun pulse, result still returned.
//     rst low during ALU_B -> all outputs 0 next cycle; next AA frame decodes normally.

Source files
------------

// File: rtl/sys_cmd_decoder_pkg.sv
// Shared constants for the system command decoder: frame opcodes,
// FSM state codes and the register-file slots that hold ALU operands.
package sys_cmd_decoder_pkg;

  // Frame opcodes (first byte of every frame)
  localparam logic [7:0] OPC_WR     = 8'hAA;  // AA addr data
  localparam logic [7:0] OPC_RD     = 8'hBB;  // BB addr
  localparam logic [7:0] OPC_ALU    = 8'hCC;  // CC opA opB fun
  localparam logic [7:0] OPC_ALU_FN = 8'hDD;  // DD fun

  // Register-file slots used for the ALU operands
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  // FSM state codes
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_ALU_A    = 4'd5;
  localparam logic [3:0] ST_ALU_B    = 4'd6;
  localparam logic [3:0] ST_ALU_FN   = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_RSP      = 4'd9;

  // States in which an incoming RX byte cannot be consumed
  function automatic logic rx_blocked(input logic [3:0] st);
    return (st == ST_RD_WAIT) || (st == ST_ALU_WAIT) || (st == ST_RSP);
  endfunction

endpackage

// File: rtl/sys_cmd_decoder.sv
// Command-frame decoder: turns synchronized RX bytes into register-file
// writes/reads and ALU operations, and returns read/ALU results as
// response words held until the TX packer accepts them.
module sys_cmd_decoder
  import sys_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_REGS       = 8,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_LEN,
  output logic                    RSP_VLD,
  input  logic                    RSP_RDY,
  output logic                    clk_div_en,
  output logic                    cmd_error,
  output logic                    overrun
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen during the last permitted wait cycle
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] REG_LIMIT = DATA_WIDTH'(NUM_REGS);

  logic [3:0]           state_r;
  logic [CNT_WIDTH-1:0] wait_cnt_r;
  logic                 addr_ok_s;

  assign addr_ok_s = (RX_P_DATA < REG_LIMIT);

  // Frame FSM with registered strobes, held fields and wait timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      address    <= '0;
      WrData     <= '0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      CLK_EN     <= 1'b0;
      RSP_DATA   <= '0;
      RSP_LEN    <= 1'b0;
      RSP_VLD    <= 1'b0;
      clk_div_en <= 1'b0;
      cmd_error  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      clk_div_en <= 1'b1;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      cmd_error  <= 1'b0;
      overrun    <= RX_D_VLD & rx_blocked(state_r);
      case (state_r)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              OPC_WR:     state_r <= ST_WR_ADDR;
              OPC_RD:     state_r <= ST_RD_ADDR;
              OPC_ALU:    state_r <= ST_ALU_A;
              OPC_ALU_FN: state_r <= ST_ALU_FN;
              default:    cmd_error <= 1'b1;
            endcase
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            if (!addr_ok_s) begin
              cmd_error <= 1'b1;
              state_r   <= ST_IDLE;
            end else begin
              address <= RX_P_DATA[ADDR_WIDTH-1:0];
              if (state_r == ST_RD_ADDR) begin
                RdEn       <= 1'b1;
                wait_cnt_r <= '0;
                state_r    <= ST_RD_WAIT;
              end else begin
                state_r <= ST_WR_DATA;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            WrData  <= RX_P_DATA;
            state_r <= ST_IDLE;
          end
        end
        ST_ALU_A, ST_ALU_B: begin
          if (RX_D_VLD) begin
            WrEn   <= 1'b1;
            WrData <= RX_P_DATA;
            if (state_r == ST_ALU_A) begin
              address <= ADDR_WIDTH'(OPA_ADDR);
              state_r <= ST_ALU_B;
            end else begin
              address <= ADDR_WIDTH'(OPB_ADDR);
              state_r <= ST_ALU_FN;
            end
          end
        end
        ST_ALU_FN: begin
          if (RX_D_VLD) begin
            ALU_FUN    <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN     <= 1'b1;
            CLK_EN     <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= ST_ALU_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // A strobe on the final count still wins over the timeout
          if (RdData_Valid) begin
            RSP_DATA <= {{DATA_WIDTH{1'b0}}, RdData};
            RSP_LEN  <= 1'b0;
            RSP_VLD  <= 1'b1;
            state_r  <= ST_RSP;
          end else if (wait_cnt_r == CNT_LAST) begin
            cmd_error <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        ST_ALU_WAIT: begin
          if (OUT_Valid) begin
            RSP_DATA <= ALU_OUT;
            RSP_LEN  <= 1'b1;
            RSP_VLD  <= 1'b1;
            ALU_EN   <= 1'b0;
            CLK_EN   <= 1'b0;
            state_r  <= ST_RSP;
          end else if (wait_cnt_r == CNT_LAST) begin
            cmd_error <= 1'b1;
            ALU_EN    <= 1'b0;
            CLK_EN    <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end
        ST_RSP: begin
          if (RSP_RDY) begin
            RSP_VLD <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Bench for sys_cmd_decoder: directed frames with literal expectations,
// then randomized traffic checked every cycle against a frame-level model.
module tb_sys_cmd_decoder;

  localparam int TMO = 255;

  logic        clk;
  logic        rst;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        WrEn, RdEn;
  logic [3:0]  address;
  logic [7:0]  WrData;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_EN;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic [15:0] RSP_DATA;
  logic        RSP_LEN, RSP_VLD, RSP_RDY;
  logic        clk_div_en, cmd_error, overrun;

  int total = 0;
  int bad   = 0;

  sys_cmd_decoder dut (
    .clk(clk), .rst(rst), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .address(address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_FUN(ALU_FUN),
    .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .RSP_DATA(RSP_DATA), .RSP_LEN(RSP_LEN), .RSP_VLD(RSP_VLD), .RSP_RDY(RSP_RDY),
    .clk_div_en(clk_div_en), .cmd_error(cmd_error), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic        e_wren, e_rden, e_alu_en, e_clk_en, e_len, e_vld, e_div, e_err, e_ovr;
  logic [3:0]  e_addr, e_fun;
  logic [7:0]  e_wrdata;
  logic [15:0] e_rsp;
  logic [7:0]  fq[$];   // bytes of the frame collected so far
  int          waiting = 0;  // 0 none, 1 register read, 2 ALU result
  int          wait_n  = 0;  // wait cycles elapsed
  bit          in_rsp  = 1'b0;

  // Model: next output values from the inputs seen at this edge
  always @(posedge clk) begin
    logic [7:0] b;
    int n;
    if (!rst) begin
      {e_wren, e_rden, e_alu_en, e_clk_en, e_len, e_vld, e_div, e_err, e_ovr} = '0;
      e_addr = '0; e_fun = '0; e_wrdata = '0; e_rsp = '0;
      fq.delete(); waiting = 0; wait_n = 0; in_rsp = 1'b0;
    end else begin
      e_wren = 1'b0; e_rden = 1'b0; e_err = 1'b0; e_ovr = 1'b0; e_div = 1'b1;
      if (waiting != 0) begin
        e_ovr = RX_D_VLD;
        wait_n++;
        if (waiting == 1 && RdData_Valid) begin
          e_rsp = {8'h00, RdData}; e_len = 1'b0; e_vld = 1'b1;
          waiting = 0; in_rsp = 1'b1;
        end else if (waiting == 2 && OUT_Valid) begin
          e_rsp = ALU_OUT; e_len = 1'b1; e_vld = 1'b1;
          e_alu_en = 1'b0; e_clk_en = 1'b0; waiting = 0; in_rsp = 1'b1;
        end else if (wait_n == TMO) begin
          e_err = 1'b1; e_alu_en = 1'b0; e_clk_en = 1'b0; waiting = 0;
        end
      end else if (in_rsp) begin
        e_ovr = RX_D_VLD;
        if (RSP_RDY) begin e_vld = 1'b0; in_rsp = 1'b0; end
      end else if (RX_D_VLD) begin
        b = RX_P_DATA;
        fq.push_back(b);
        n = fq.size();
        case (fq[0])
          8'hAA: begin
            if (n == 2) begin
              if (b >= 8'd8) begin e_err = 1'b1; fq.delete(); end
              else e_addr = b[3:0];
            end else if (n == 3) begin
              e_wren = 1'b1; e_wrdata = b; fq.delete();
            end
          end
          8'hBB: begin
            if (n == 2) begin
              if (b >= 8'd8) e_err = 1'b1;
              else begin e_addr = b[3:0]; e_rden = 1'b1; waiting = 1; wait_n = 0; end
              fq.delete();
            end
          end
          8'hCC: begin
            if (n == 2) begin e_wren = 1'b1; e_addr = 4'd0; e_wrdata = b; end
            else if (n == 3) begin e_wren = 1'b1; e_addr = 4'd1; e_wrdata = b; end
            else if (n == 4) begin
              e_fun = b[3:0]; e_alu_en = 1'b1; e_clk_en = 1'b1;
              waiting = 2; wait_n = 0; fq.delete();
            end
          end
          8'hDD: begin
            if (n == 2) begin
              e_fun = b[3:0]; e_alu_en = 1'b1; e_clk_en = 1'b1;
              waiting = 2; wait_n = 0; fq.delete();
            end
          end
          default: begin e_err = 1'b1; fq.delete(); end
        endcase
      end
    end
  end

  // Compare every DUT output against the model, away from the active edge
  always @(negedge clk) begin
    chk("WrEn",       32'(WrEn),       32'(e_wren));
    chk("RdEn",       32'(RdEn),       32'(e_rden));
    chk("address",    32'(address),    32'(e_addr));
    chk("WrData",     32'(WrData),     32'(e_wrdata));
    chk("ALU_FUN",    32'(ALU_FUN),    32'(e_fun));
    chk("ALU_EN",     32'(ALU_EN),     32'(e_alu_en));
    chk("CLK_EN",     32'(CLK_EN),     32'(e_clk_en));
    chk("RSP_DATA",   32'(RSP_DATA),   32'(e_rsp));
    chk("RSP_LEN",    32'(RSP_LEN),    32'(e_len));
    chk("RSP_VLD",    32'(RSP_VLD),    32'(e_vld));
    chk("clk_div_en", 32'(clk_div_en), 32'(e_div));
    chk("cmd_error",  32'(cmd_error),  32'(e_err));
    chk("overrun",    32'(overrun),    32'(e_ovr));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
  endtask

  initial begin
    rst = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RdData = 8'h00;
    RdData_Valid = 1'b0; ALU_OUT = 16'h0000; OUT_Valid = 1'b0; RSP_RDY = 1'b0;
    repeat (3) tick();
    chk("rst_clk_div_en", 32'(clk_div_en), 0);
    chk("rst_rsp_vld",    32'(RSP_VLD), 0);
    rst = 1'b1;
    tick();
    chk("div_en_after_rst", 32'(clk_div_en), 1);

    // Register write: AA 05 3C
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("t1_wren", 32'(WrEn), 1);
    chk("t1_addr", 32'(address), 5);
    chk("t1_data", 32'(WrData), 32'h3C);
    tick();
    chk("t1_wren_off", 32'(WrEn), 0);
    chk("t1_no_rsp",   32'(RSP_VLD), 0);

    // Register read: BB 05, data two cycles after RdEn, TX stalls 3 cycles
    send(8'hBB); send(8'h05);
    chk("t2_rden", 32'(RdEn), 1);
    tick(); tick();
    RdData = 8'h3C; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0; RdData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("t2_vld",  32'(RSP_VLD), 1);
      chk("t2_data", 32'(RSP_DATA), 32'h003C);
      chk("t2_len",  32'(RSP_LEN), 0);
      tick();
    end
    RSP_RDY = 1'b1;
    tick();
    RSP_RDY = 1'b0;
    chk("t2_vld_clear", 32'(RSP_VLD), 0);

    // ALU: CC 0A 14 00, stray byte while waiting, result 001E
    send(8'hCC); send(8'h0A);
    chk("t3_wr_a_en", 32'(WrEn), 1);
    chk("t3_wr_a_ad", 32'(address), 0);
    chk("t3_wr_a_d",  32'(WrData), 32'h0A);
    send(8'h14);
    chk("t3_wr_b_ad", 32'(address), 1);
    chk("t3_wr_b_d",  32'(WrData), 32'h14);
    send(8'h00);
    chk("t3_fun",    32'(ALU_FUN), 0);
    chk("t3_alu_en", 32'(ALU_EN), 1);
    chk("t3_clk_en", 32'(CLK_EN), 1);
    chk("t3_no_wr",  32'(WrEn), 0);
    tick();
    send(8'h55);
    chk("t5_overrun",   32'(overrun), 1);
    chk("t5_alu_still", 32'(ALU_EN), 1);
    ALU_OUT = 16'h001E; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    chk("t3_alu_off", 32'(ALU_EN), 0);
    chk("t3_vld",     32'(RSP_VLD), 1);
    chk("t3_data",    32'(RSP_DATA), 32'h001E);
    chk("t3_len",     32'(RSP_LEN), 1);
    RSP_RDY = 1'b1; tick(); RSP_RDY = 1'b0;

    // Illegal opcode, illegal address, read timeout
    send(8'h7F);
    chk("t4_bad_opc", 32'(cmd_error), 1);
    tick();
    chk("t4_err_pulse", 32'(cmd_error), 0);
    send(8'hBB); send(8'h09);
    chk("t4_bad_addr", 32'(cmd_error), 1);
    chk("t4_no_rden",  32'(RdEn), 0);
    send(8'hBB); send(8'h02);
    chk("t4_rden", 32'(RdEn), 1);
    repeat (TMO - 1) tick();
    chk("t4_no_err_yet", 32'(cmd_error), 0);
    tick();
    chk("t4_timeout", 32'(cmd_error), 1);

    // Reset in the middle of an ALU frame, then a clean write
    send(8'hCC); send(8'h11);
    rst = 1'b0;
    tick();
    chk("t5_rst_wren", 32'(WrEn), 0);
    chk("t5_rst_wd",   32'(WrData), 0);
    chk("t5_rst_div",  32'(clk_div_en), 0);
    rst = 1'b1;
    tick();
    send(8'hAA); send(8'h03); send(8'h77);
    chk("t5_wren", 32'(WrEn), 1);
    chk("t5_addr", 32'(address), 3);
    chk("t5_data", 32'(WrData), 32'h77);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 5000; c++) begin
      int r;
      rst      = ($urandom_range(0, 399) != 0);
      RX_D_VLD = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: RX_P_DATA = 8'hAA;
        1: RX_P_DATA = 8'hBB;
        2: RX_P_DATA = 8'hCC;
        3: RX_P_DATA = 8'hDD;
        4, 5: RX_P_DATA = 8'($urandom_range(0, 9));
        default: RX_P_DATA = 8'($urandom);
      endcase
      RdData       = 8'($urandom);
      RdData_Valid = ($urandom_range(0, 5) == 0);
      ALU_OUT      = 16'($urandom);
      OUT_Valid    = ($urandom_range(0, 5) == 0);
      RSP_RDY      = ($urandom_range(0, 1) == 0);
      tick();
    end

    rst = 1'b1; RX_D_VLD = 1'b0; RdData_Valid = 1'b0; OUT_Valid = 1'b0; RSP_RDY = 1'b1;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
